// File: rtl/ccc_reconfig_ctrl_if.sv
// ccc_reconfig_ctrl_if: bundle between the reconfiguration controller, the CCC APB
// configuration port and the external per-profile configuration table.
//   psel/penable/pwrite/paddr/pwdata : APB master request (controller -> CCC)
//   prdata                           : APB read data (CCC -> controller)
//   tbl_sel/tbl_idx                  : table lookup key (controller -> table)
//   tbl_addr/tbl_data                : combinational table result (table -> controller)
interface ccc_reconfig_ctrl_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [5:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic [1:0] tbl_sel;
  logic [3:0] tbl_idx;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_data;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, tbl_sel, tbl_idx,
    input  prdata, tbl_addr, tbl_data
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, tbl_sel, tbl_idx,
    output prdata, tbl_addr, tbl_data
  );
endinterface

// File: rtl/ccc_reconfig_ctrl.sv
// ccc_reconfig_ctrl: programs a CCC PLL from a profile table over APB, verifies every
// register by readback, releases the PLL reset and waits for a stable lock, retrying the
// whole sequence on readback mismatch or lock timeout.
//   pclk_i, rst_i      : clock and synchronous active-high reset
//   start_i, profile_i : one-cycle (re)configure request and the profile to use
//   lock_i             : PLL lock, asynchronous to pclk_i
//   pll_arst_n_o       : active-low PLL reset
//   busy_o, ready_o, error_o, err_code_o, retry_cnt_o, lock_lost_o : status
//   bus                : APB master + config table lookup
module ccc_reconfig_ctrl #(
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned ARST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                       pclk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [1:0]                 profile_i,
  input  logic                       lock_i,
  output logic                       pll_arst_n_o,
  output logic                       busy_o,
  output logic                       ready_o,
  output logic                       error_o,
  output logic [1:0]                 err_code_o,
  output logic [1:0]                 retry_cnt_o,
  output logic                       lock_lost_o,
  ccc_reconfig_ctrl_if.master        bus
);

  localparam int unsigned ArstW  = $clog2(ARST_CYCLES + 1);
  localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned RetryW = (MAX_RETRY < 3) ? 2 : $clog2(MAX_RETRY + 1);

  localparam logic [3:0]        LastIdx  = 4'(NUM_REGS - 1);
  localparam logic [ArstW-1:0]  ArstLast = ArstW'(ARST_CYCLES - 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(LOCK_TIMEOUT - 1);
  // STABLE is left when the count reaches STABLE_CYCLES, so it lasts STABLE_CYCLES+1 cycles.
  localparam logic [StabW-1:0]  StabLast = StabW'(STABLE_CYCLES);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  localparam logic [1:0] ErrReadback = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StArst, StWrSetup, StWrAccess, StRdSetup, StRdAccess,
    StRelease, StWaitLock, StStable, StRun, StFail
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sel_q, sel_d;
  logic [3:0]          idx_q, idx_d;
  logic [ArstW-1:0]    arst_cnt_q, arst_cnt_d;
  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [StabW-1:0]    stab_cnt_q, stab_cnt_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [1:0]          err_q, err_d;
  logic                lost_q, lost_d;
  logic                pll_arst_n_q, pll_arst_n_d;
  logic                lock_meta_q, lock_s_q;
  logic                do_retry;
  logic                start_ok;

  assign start_ok = start_i && (state_q inside {StIdle, StRun, StFail});

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    arst_cnt_d = '0;
    tmo_cnt_d  = '0;
    stab_cnt_d = '0;
    retry_d    = retry_q;
    err_d      = err_q;
    lost_d     = lost_q;
    do_retry   = 1'b0;

    unique case (state_q)
      StIdle, StFail: ;
      StRun: begin
        if (!lock_s_q) begin
          lost_d  = 1'b1;
          state_d = StWaitLock;
        end
      end
      StArst: begin
        idx_d = '0;
        if (arst_cnt_q == ArstLast) state_d = StWrSetup;
        else arst_cnt_d = arst_cnt_q + 1'b1;
      end
      StWrSetup: state_d = StWrAccess;
      StWrAccess: begin
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StRdSetup;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StWrSetup;
        end
      end
      StRdSetup: state_d = StRdAccess;
      StRdAccess: begin
        if (bus.prdata != bus.tbl_data) begin
          err_d    = ErrReadback;
          do_retry = 1'b1;
        end else if (idx_q == LastIdx) begin
          state_d = StRelease;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StRdSetup;
        end
      end
      StRelease: state_d = StWaitLock;
      StWaitLock: begin
        tmo_cnt_d = tmo_cnt_q;
        if (lock_s_q) begin
          state_d = StStable;
        end else if (tmo_cnt_q == TmoLast) begin
          err_d    = ErrTimeout;
          do_retry = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StStable: begin
        // The timeout budget keeps running across lock glitches.
        tmo_cnt_d = tmo_cnt_q;
        if (!lock_s_q) state_d = StWaitLock;
        else if (stab_cnt_q == StabLast) state_d = StRun;
        else stab_cnt_d = stab_cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (do_retry) begin
      if (retry_q < RetryMax) begin
        retry_d = retry_q + 1'b1;
        state_d = StArst;
      end else begin
        state_d = StFail;
      end
    end

    if (start_ok) begin
      sel_d   = profile_i;
      retry_d = '0;
      err_d   = '0;
      lost_d  = 1'b0;
      state_d = StArst;
    end

    // Registered from the next state so the PLL reset never glitches.
    pll_arst_n_d = !(state_d inside {StArst, StWrSetup, StWrAccess, StRdSetup, StRdAccess,
                                     StRelease});
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      idx_q        <= '0;
      arst_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      stab_cnt_q   <= '0;
      retry_q      <= '0;
      err_q        <= '0;
      lost_q       <= 1'b0;
      pll_arst_n_q <= 1'b1;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      arst_cnt_q   <= arst_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      lost_q       <= lost_d;
      pll_arst_n_q <= pll_arst_n_d;
      lock_meta_q  <= lock_i;
      lock_s_q     <= lock_meta_q;
    end
  end

  assign bus.psel    = state_q inside {StWrSetup, StWrAccess, StRdSetup, StRdAccess};
  assign bus.penable = state_q inside {StWrAccess, StRdAccess};
  assign bus.pwrite  = state_q inside {StWrSetup, StWrAccess};
  assign bus.paddr   = bus.psel ? bus.tbl_addr : 6'd0;
  assign bus.pwdata  = bus.pwrite ? bus.tbl_data : 8'd0;
  assign bus.tbl_sel = sel_q;
  assign bus.tbl_idx = idx_q;

  assign pll_arst_n_o = pll_arst_n_q;
  assign busy_o       = !(state_q inside {StIdle, StRun, StFail});
  assign ready_o      = (state_q == StRun);
  assign error_o      = (state_q == StFail);
  assign err_code_o   = err_q;
  assign lock_lost_o  = lost_q;

  always_comb begin
    if (retry_q >= RetryW'(3)) retry_cnt_o = 2'd3;
    else retry_cnt_o = retry_q[1:0];
  end

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// tb_ccc_reconfig_ctrl: scoreboard bench for ccc_reconfig_ctrl. Expected APB accesses are
// queued when a START is driven and popped by a bus monitor on every access phase.
module tb_ccc_reconfig_ctrl;
  localparam int unsigned NumRegs      = 8;
  localparam int unsigned StableCycles = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] profile = 2'd0;
  logic       lock = 1'b0;
  logic       pll_arst_n, busy, ready, error, lock_lost;
  logic [1:0] err_code, retry_cnt;

  logic       corrupt_en = 1'b0;
  logic [3:0] corrupt_idx = 4'd5;
  logic [7:0] mem [64];
  logic [15:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  ccc_reconfig_ctrl_if bus ();

  ccc_reconfig_ctrl dut (
    .pclk_i       (clk),
    .rst_i        (rst),
    .start_i      (start),
    .profile_i    (profile),
    .lock_i       (lock),
    .pll_arst_n_o (pll_arst_n),
    .busy_o       (busy),
    .ready_o      (ready),
    .error_o      (error),
    .err_code_o   (err_code),
    .retry_cnt_o  (retry_cnt),
    .lock_lost_o  (lock_lost),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] tab_addr(input logic [1:0] s, input logic [3:0] i);
    return {s, i};
  endfunction

  function automatic logic [7:0] tab_data(input logic [1:0] s, input logic [3:0] i);
    return 8'({s, i}) * 8'd37 + 8'h5a;
  endfunction

  function automatic logic [15:0] pack_exp(input logic wr, input logic [1:0] s,
                                           input logic [3:0] i);
    return {1'b0, wr, tab_addr(s, i), (wr ? tab_data(s, i) : 8'h00)};
  endfunction

  assign bus.tbl_addr = tab_addr(bus.tbl_sel, bus.tbl_idx);
  assign bus.tbl_data = tab_data(bus.tbl_sel, bus.tbl_idx);
  assign bus.prdata   = (corrupt_en && bus.paddr[3:0] == corrupt_idx) ?
                        (mem[bus.paddr] ^ 8'hff) : mem[bus.paddr];

  // CCC register file model.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (bus.psel && bus.penable && bus.pwrite) begin
      mem[bus.paddr] <= bus.pwdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: every access phase must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [15:0] got;
    logic [15:0] exp;
    if (bus.psel && bus.penable) begin
      got = {1'b0, bus.pwrite, bus.paddr, (bus.pwrite ? bus.pwdata : 8'h00)};
      if (exp_q.size() == 0) begin
        check_eq("apb_unexpected", 32'(got), 32'h8000);
      end else begin
        exp = exp_q.pop_front();
        check_eq(bus.pwrite ? "apb_write" : "apb_read", 32'(got), 32'(exp));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] p);
    start   = 1'b1;
    profile = p;
    tick();
    start   = 1'b0;
  endtask

  task automatic push_attempt(input logic [1:0] s, input int rd_last);
    for (int i = 0; i < NumRegs; i++) exp_q.push_back(pack_exp(1'b1, s, 4'(i)));
    for (int i = 0; i <= rd_last; i++) exp_q.push_back(pack_exp(1'b0, s, 4'(i)));
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_status"},
             32'({pll_arst_n, busy, ready, error, lock_lost, err_code, retry_cnt}), 32'h100);
    check_eq({pfx, "_apb"},
             32'({bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}), 32'h0);
    check_eq({pfx, "_tbl"}, 32'({bus.tbl_sel, bus.tbl_idx}), 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int c;
    int n_arst;

    // Reset and nominal programming of profile 2.
    lock = 1'b1;
    tick(3);
    rst = 1'b0;
    check_reset_state("reset");

    push_attempt(2'd2, NumRegs - 1);
    do_start(2'd2);
    n_arst = 0;
    c = 0;
    while (!bus.psel && c < 100) begin
      if (!pll_arst_n) n_arst++;
      tick();
      c++;
    end
    check_eq("arst_cycles", 32'(n_arst), 32'd16);
    check_eq("first_setup", 32'({busy, bus.tbl_sel, bus.pwrite, bus.penable}), 32'b11010);
    c = 0;
    while (!pll_arst_n && c < 200) begin
      tick();
      c++;
    end
    c = 0;
    while (!ready && c < 2000) begin
      tick();
      c++;
    end
    check_eq("ready_latency", 32'(c), 32'(StableCycles + 2));
    check_eq("nominal_status", 32'({busy, error, err_code, retry_cnt}), 32'h0);
    check_eq("nominal_sb_empty", 32'(exp_q.size()), 32'd0);

    // Lock lost in RUN, then regained.
    lock = 1'b0;
    c = 0;
    while (ready && c < 10) begin
      tick();
      c++;
    end
    check_eq("loss_within_3", 32'(c <= 3), 32'd1);
    check_eq("loss_flags", 32'({ready, lock_lost, retry_cnt}), 32'b0100);
    lock = 1'b1;
    c = 0;
    while (!ready && c < 2000) begin
      tick();
      c++;
    end
    check_eq("regain_latency", 32'(c), 32'(StableCycles + 4));
    check_eq("lost_sticky", 32'(lock_lost), 32'd1);

    // Restart with profile 1, START clears LOCK_LOST; lock glitch during STABLE.
    push_attempt(2'd1, NumRegs - 1);
    do_start(2'd1);
    check_eq("lost_cleared", 32'(lock_lost), 32'd0);
    c = 0;
    while (!pll_arst_n && c < 200) begin
      tick();
      c++;
    end
    c = 0;
    while (!ready && c < 2000) begin
      if (c == 101) lock = 1'b0;
      if (c == 104) lock = 1'b1;
      tick();
      c++;
    end
    check_eq("glitch_latency", 32'(c), 32'(StableCycles + 108));
    check_eq("glitch_no_retry", 32'({error, retry_cnt, err_code}), 32'h0);
    check_eq("glitch_sb_empty", 32'(exp_q.size()), 32'd0);

    // Readback mismatch on entry 5 every attempt.
    corrupt_en = 1'b1;
    for (int a = 0; a < 4; a++) push_attempt(2'd3, 5);
    do_start(2'd3);
    c = 0;
    while (!error && c < 5000) begin
      tick();
      c++;
    end
    corrupt_en = 1'b0;
    check_eq("mismatch_fail", 32'({error, busy, ready}), 32'b100);
    check_eq("mismatch_code", 32'(err_code), 32'b01);
    check_eq("mismatch_retries", 32'(retry_cnt), 32'd3);
    check_eq("mismatch_sb_empty", 32'(exp_q.size()), 32'd0);

    // Lock never arrives.
    lock = 1'b0;
    for (int a = 0; a < 4; a++) push_attempt(2'd0, NumRegs - 1);
    do_start(2'd0);
    c = 0;
    while (!pll_arst_n && c < 200) begin
      tick();
      c++;
    end
    c = 0;
    while (pll_arst_n && c < 5000) begin
      tick();
      c++;
    end
    check_eq("wait_lock_len", 32'(c), 32'd4096);
    check_eq("timeout_retry1", 32'({err_code, retry_cnt}), 32'b1001);
    c = 0;
    while (!error && c < 20000) begin
      tick();
      c++;
    end
    check_eq("timeout_code", 32'(err_code), 32'b10);
    check_eq("timeout_state", 32'({error, pll_arst_n, retry_cnt}), 32'b1111);
    check_eq("timeout_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during WR_ACCESS of entry 3; START while busy must be ignored.
    lock = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(pack_exp(1'b1, 2'd1, 4'(i)));
    do_start(2'd1);
    tick(18);
    do_start(2'd2);
    check_eq("busy_start_ignored", 32'({busy, bus.tbl_sel}), 32'b101);
    c = 0;
    while (!(bus.psel && bus.penable && bus.pwrite && bus.tbl_idx == 4'd3) && c < 200) begin
      tick();
      c++;
    end
    rst = 1'b1;
    tick();
    check_reset_state("midwrite_reset");
    rst = 1'b0;
    tick(5);
    check_eq("midwrite_idle", 32'({busy, bus.psel}), 32'h0);
    check_eq("midwrite_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccc_reconfig_ctrl.md
CCC_RECONFIG_CTRL -- requirements
Module: ccc_reconfig_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 8: CCC config bytes written per profile, range 1..16.
REQ-002 Parameter ARST_CYCLES, default 16: PCLK cycles PLL_ARST_N is held low before programming.
REQ-003 Parameter LOCK_TIMEOUT, default 4096: maximum PCLK cycles to wait for synchronized LOCK after reset release.
REQ-004 Parameter STABLE_CYCLES, default 256: consecutive synchronized-LOCK-high cycles required before READY asserts.
REQ-005 Parameter MAX_RETRY, default 3: full-sequence retries after the first attempt before FAIL.
REQ-006 PCLK  in  1  sole clock; every flop rising-edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 START  in  1  one-cycle request to (re)configure with PROFILE.
REQ-009 PROFILE  in  2  profile index, sampled only on an accepted START.
REQ-010 TBL_SEL  out  2  latched profile, presented to the external config table.
REQ-011 TBL_IDX  out  4  table entry index, 0..NUM_REGS-1.
REQ-012 TBL_ADDR  in  6  CCC register address for {TBL_SEL,TBL_IDX}, combinational, valid the same cycle.
REQ-013 TBL_DATA  in  8  CCC register value for {TBL_SEL,TBL_IDX}, combinational, valid the same cycle.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB master controls to the CCC configuration port.
REQ-015 PADDR  out  6; PWDATA  out  8; PRDATA  in  8  APB address, write data and read data.
REQ-016 PLL_ARST_N  out  1  active-low PLL reset to the CCC.
REQ-017 LOCK  in  1  CCC PLL lock, asynchronous to PCLK.
REQ-018 BUSY  out  1  high in every state except IDLE, RUN and FAIL.
REQ-019 READY  out  1  high only in RUN.
REQ-020 ERROR  out  1  high only in FAIL; ERR_CODE  out  2  01 = readback mismatch, 10 = lock timeout, 00 = none.
REQ-021 RETRY_CNT  out  2  retries used in the current request, saturating at 3.
REQ-022 LOCK_LOST  out  1  sticky flag set when LOCK drops in RUN; cleared by an accepted START or RST.

Function
REQ-023 LOCK shall pass through a 2-flop synchronizer (LOCK_S); all lock decisions use LOCK_S only.
REQ-024 States shall be IDLE, ARST, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RELEASE, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-025 START shall be accepted in IDLE, RUN or FAIL; on acceptance the block latches PROFILE to TBL_SEL, clears RETRY_CNT, ERR_CODE and LOCK_LOST, and enters ARST. START in any other state is ignored.
REQ-026 ARST: PLL_ARST_N=0 for exactly ARST_CYCLES cycles; TBL_IDX=0; then WR_SETUP.
REQ-027 WR_SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR=TBL_ADDR, PWDATA=TBL_DATA; next WR_ACCESS with PENABLE=1 and the same PADDR/PWDATA.
REQ-028 After WR_ACCESS the block shall go to RD_SETUP if TBL_IDX=NUM_REGS-1, resetting TBL_IDX to 0; otherwise it increments TBL_IDX and returns to WR_SETUP.
REQ-029 Reads shall use the same two-phase APB timing with PWRITE=0; PRDATA is compared with TBL_DATA in RD_ACCESS.
REQ-030 On a mismatch the block shall set ERR_CODE=01 and retry. After the last entry matches, it goes to RELEASE.
REQ-031 PLL_ARST_N shall stay 0 from ARST through RELEASE. RELEASE lasts one cycle and sets PLL_ARST_N=1, which holds until the next ARST.
REQ-032 WAIT_LOCK: the timeout counter starts at 0 on entry. When LOCK_S=1 the block goes to STABLE. When the counter reaches LOCK_TIMEOUT-1 with LOCK_S=0, it sets ERR_CODE=10 and retries.
REQ-033 STABLE: a stable counter counts consecutive LOCK_S=1 cycles; LOCK_S=0 returns the block to WAIT_LOCK without resetting the timeout counter. After STABLE_CYCLES cycles the block enters RUN.
REQ-034 Retry means: if RETRY_CNT<MAX_RETRY, increment RETRY_CNT and go to ARST; otherwise go to FAIL.
REQ-035 In RUN, LOCK_S=0 shall set LOCK_LOST, drop READY the next cycle, and enter WAIT_LOCK with a fresh timeout counter and RETRY_CNT unchanged.
REQ-036 PSEL and PENABLE shall be 0 in every state other than the four APB states.

Reset
REQ-037 RST has priority over START and over every state.
REQ-038 RST puts the block in IDLE: PLL_ARST_N=1, PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, TBL_SEL=0, TBL_IDX=0, BUSY=READY=ERROR=0, ERR_CODE=0, RETRY_CNT=0, LOCK_LOST=0, all counters 0, synchronizer flops 0.
REQ-039 RST during an APB transfer shall drop PSEL and PENABLE on the next edge with no further accesses.

Verification
REQ-040 Nominal: RST, START with PROFILE=2 and LOCK held 1 -> 16 ARST cycles, then 8 write pairs and 8 read pairs with TBL_SEL=2; READY=1 exactly STABLE_CYCLES+3 cycles after RELEASE; ERROR=0.
REQ-041 Readback mismatch: corrupt PRDATA on entry 5 for every attempt -> 4 full attempts, RETRY_CNT=3, FAIL with ERROR=1 and ERR_CODE=01.
REQ-042 Lock timeout: LOCK held 0 -> after each RELEASE, WAIT_LOCK lasts 4096 cycles; after 4 attempts, ERR_CODE=10 and PLL_ARST_N=1.
REQ-043 Lock glitch: LOCK drops for 3 cycles at stable count 100 -> STABLE restarts; READY is delayed accordingly; no retry.
REQ-044 Loss in RUN: LOCK falls -> READY=0 and LOCK_LOST=1 within 3 cycles. LOCK returns -> READY after STABLE_CYCLES. A later START clears LOCK_LOST.
REQ-045 Reset mid-write: assert RST in WR_ACCESS of entry 3 -> all outputs equal REQ-038 values the next cycle; START while BUSY is ignored.
